// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V pipeline.
// Holds widths, ALU op classes, operand-A selects and forward selects.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    localparam logic [1:0] ASEL_RS1  = 2'b00;
    localparam logic [1:0] ASEL_PC   = 2'b01;
    localparam logic [1:0] ASEL_ZERO = 2'b10;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Per-operand bypass: picks EX/MEM, MEM/WB or register-file data.
// EX/MEM is the younger producer, so it wins; x0 is never bypassed.
module forward_unit
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = riscv_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              ex_mem_reg_write,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [XLEN-1:0]   ex_mem_result,
    input  logic              mem_wb_reg_write,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic [XLEN-1:0]   mem_wb_result,
    output logic [XLEN-1:0]   data
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (ex_mem_reg_write && ex_mem_rd != '0 &&
            ex_mem_rd == rs_addr) begin
            sel = FWD_EXMEM;
        end else if (mem_wb_reg_write && mem_wb_rd != '0 &&
                     mem_wb_rd == rs_addr) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        unique case (sel)
            FWD_EXMEM: data = ex_mem_result;
            FWD_MEMWB: data = mem_wb_result;
            default:   data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubbles.
// Feeds the EX-stage ALU and carries MEM/WB control downstream.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = riscv_pkg::REG_AW
) (
    input  logic              Clk_i,
    input  logic              Rst_ni,
    input  logic              Valid_i,
    input  logic [XLEN-1:0]   Pc_i,
    input  logic [XLEN-1:0]   Rs1Data_i,
    input  logic [XLEN-1:0]   Rs2Data_i,
    input  logic [XLEN-1:0]   Imm_i,
    input  logic [REG_AW-1:0] Rs1Addr_i,
    input  logic [REG_AW-1:0] Rs2Addr_i,
    input  logic [REG_AW-1:0] RdAddr_i,
    input  logic              UseRs1_i,
    input  logic              UseRs2_i,
    input  logic [2:0]        Funct3_i,
    input  logic [6:0]        Funct7_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [1:0]        ASel_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemToReg_i,
    input  logic              Stall_i,
    input  logic              Flush_i,
    input  logic              ExMemRegWrite_i,
    input  logic [REG_AW-1:0] ExMemRd_i,
    input  logic [XLEN-1:0]   ExMemResult_i,
    input  logic              MemWbRegWrite_i,
    input  logic [REG_AW-1:0] MemWbRd_i,
    input  logic [XLEN-1:0]   MemWbResult_i,
    output logic [XLEN-1:0]   OperandA_o,
    output logic [XLEN-1:0]   OperandB_o,
    output logic [2:0]        Funct3_o,
    output logic [6:0]        Funct7_o,
    output logic [1:0]        ALUOp_o,
    output logic [XLEN-1:0]   StoreData_o,
    output logic [XLEN-1:0]   Pc_o,
    output logic [REG_AW-1:0] RdAddr_o,
    output logic              Valid_o,
    output logic              RegWrite_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              MemToReg_o,
    output logic              LoadUseStall_o
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [1:0]        alu_op;
        logic [1:0]        a_sel;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } id_ex_t;

    id_ex_t q;
    id_ex_t d;
    id_ex_t cap;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            load_use;

    assign rs1_hit = UseRs1_i && (Rs1Addr_i == q.rd);
    assign rs2_hit = UseRs2_i && (Rs2Addr_i == q.rd);

    assign load_use = q.valid && q.mem_read && Valid_i &&
                      (q.rd != '0) && (rs1_hit || rs2_hit);

    always_comb begin
        cap            = '0;
        cap.valid      = 1'b1;
        cap.pc         = Pc_i;
        cap.rs1_data   = Rs1Data_i;
        cap.rs2_data   = Rs2Data_i;
        cap.imm        = Imm_i;
        cap.rs1        = Rs1Addr_i;
        cap.rs2        = Rs2Addr_i;
        cap.rd         = RdAddr_i;
        cap.funct3     = Funct3_i;
        cap.funct7     = Funct7_i;
        cap.alu_op     = ALUOp_i;
        cap.a_sel      = ASel_i;
        cap.alu_src    = ALUSrc_i;
        cap.reg_write  = RegWrite_i;
        cap.mem_read   = MemRead_i;
        cap.mem_write  = MemWrite_i;
        cap.mem_to_reg = MemToReg_i;
    end

    // Flush beats stall; a hazard bubble only lands when not stalled.
    always_comb begin
        d = q;
        priority case (1'b1)
            Flush_i:  d = '0;
            Stall_i:  d = q;
            load_use: d = '0;
            !Valid_i: d = '0;
            default:  d = cap;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
        .rs_addr          (q.rs1),
        .rf_data          (q.rs1_data),
        .ex_mem_reg_write (ExMemRegWrite_i),
        .ex_mem_rd        (ExMemRd_i),
        .ex_mem_result    (ExMemResult_i),
        .mem_wb_reg_write (MemWbRegWrite_i),
        .mem_wb_rd        (MemWbRd_i),
        .mem_wb_result    (MemWbResult_i),
        .data             (fwd_a)
    );

    forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
        .rs_addr          (q.rs2),
        .rf_data          (q.rs2_data),
        .ex_mem_reg_write (ExMemRegWrite_i),
        .ex_mem_rd        (ExMemRd_i),
        .ex_mem_result    (ExMemResult_i),
        .mem_wb_reg_write (MemWbRegWrite_i),
        .mem_wb_rd        (MemWbRd_i),
        .mem_wb_result    (MemWbResult_i),
        .data             (fwd_b)
    );

    always_comb begin
        unique case (q.a_sel)
            ASEL_RS1: OperandA_o = fwd_a;
            ASEL_PC:  OperandA_o = q.pc;
            default:  OperandA_o = '0;
        endcase
    end

    assign OperandB_o     = q.alu_src ? q.imm : fwd_b;
    assign StoreData_o    = fwd_b;
    assign Funct3_o       = q.funct3;
    assign Funct7_o       = q.funct7;
    assign ALUOp_o        = q.alu_op;
    assign Pc_o           = q.pc;
    assign RdAddr_o       = q.rd;
    assign Valid_o        = q.valid;
    assign RegWrite_o     = q.valid && q.reg_write;
    assign MemRead_o      = q.valid && q.mem_read;
    assign MemWrite_o     = q.valid && q.mem_write;
    assign MemToReg_o     = q.valid && q.mem_to_reg;
    assign LoadUseStall_o = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, load-use,
// stall/flush and PC/immediate operand selection.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        Valid_i;
    logic [31:0] Pc_i, Rs1Data_i, Rs2Data_i, Imm_i;
    logic [4:0]  Rs1Addr_i, Rs2Addr_i, RdAddr_i;
    logic        UseRs1_i, UseRs2_i;
    logic [2:0]  Funct3_i;
    logic [6:0]  Funct7_i;
    logic [1:0]  ALUOp_i, ASel_i;
    logic        ALUSrc_i, RegWrite_i, MemRead_i;
    logic        MemWrite_i, MemToReg_i;
    logic        Stall_i, Flush_i;
    logic        ExMemRegWrite_i, MemWbRegWrite_i;
    logic [4:0]  ExMemRd_i, MemWbRd_i;
    logic [31:0] ExMemResult_i, MemWbResult_i;
    logic [31:0] OperandA_o, OperandB_o, StoreData_o, Pc_o;
    logic [2:0]  Funct3_o;
    logic [6:0]  Funct7_o;
    logic [1:0]  ALUOp_o;
    logic [4:0]  RdAddr_o;
    logic        Valid_o, RegWrite_o, MemRead_o;
    logic        MemWrite_o, MemToReg_o, LoadUseStall_o;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .Clk_i(clk), .Rst_ni(rst_n), .Valid_i(Valid_i),
        .Pc_i(Pc_i), .Rs1Data_i(Rs1Data_i),
        .Rs2Data_i(Rs2Data_i), .Imm_i(Imm_i),
        .Rs1Addr_i(Rs1Addr_i), .Rs2Addr_i(Rs2Addr_i),
        .RdAddr_i(RdAddr_i), .UseRs1_i(UseRs1_i),
        .UseRs2_i(UseRs2_i), .Funct3_i(Funct3_i),
        .Funct7_i(Funct7_i), .ALUOp_i(ALUOp_i),
        .ASel_i(ASel_i), .ALUSrc_i(ALUSrc_i),
        .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .MemToReg_i(MemToReg_i),
        .Stall_i(Stall_i), .Flush_i(Flush_i),
        .ExMemRegWrite_i(ExMemRegWrite_i),
        .ExMemRd_i(ExMemRd_i), .ExMemResult_i(ExMemResult_i),
        .MemWbRegWrite_i(MemWbRegWrite_i),
        .MemWbRd_i(MemWbRd_i), .MemWbResult_i(MemWbResult_i),
        .OperandA_o(OperandA_o), .OperandB_o(OperandB_o),
        .Funct3_o(Funct3_o), .Funct7_o(Funct7_o),
        .ALUOp_o(ALUOp_o), .StoreData_o(StoreData_o),
        .Pc_o(Pc_o), .RdAddr_o(RdAddr_o), .Valid_o(Valid_o),
        .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .MemToReg_o(MemToReg_o),
        .LoadUseStall_o(LoadUseStall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        ExMemRegWrite_i = 1'b0;
        ExMemRd_i       = '0;
        ExMemResult_i   = '0;
        MemWbRegWrite_i = 1'b0;
        MemWbRd_i       = '0;
        MemWbResult_i   = '0;
    endtask

    task automatic drive(
        input logic [4:0]  rs1, rs2, rd,
        input logic [31:0] d1, d2, imm, pc,
        input logic [1:0]  op, asel,
        input logic        src, u2, rw, mr, m2r
    );
        Valid_i    = 1'b1;
        Rs1Addr_i  = rs1;
        Rs2Addr_i  = rs2;
        RdAddr_i   = rd;
        Rs1Data_i  = d1;
        Rs2Data_i  = d2;
        Imm_i      = imm;
        Pc_i       = pc;
        ALUOp_i    = op;
        ASel_i     = asel;
        ALUSrc_i   = src;
        UseRs1_i   = (asel == 2'b00);
        UseRs2_i   = u2;
        RegWrite_i = rw;
        MemRead_i  = mr;
        MemWrite_i = 1'b0;
        MemToReg_i = m2r;
        Funct3_i   = 3'b000;
        Funct7_i   = 7'h00;
    endtask

    task automatic test_reset();
        checks++;
        if (Valid_o !== 1'b0 || ALUOp_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b op=%b exp 0 00",
                     Valid_o, ALUOp_o);
        end
        checks++;
        if (OperandA_o !== 0 || LoadUseStall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got a=%h lus=%b exp 0 0",
                     OperandA_o, LoadUseStall_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd0, 32'h40,
              2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        Funct3_i = 3'b101;
        Funct7_i = 7'h20;
        step();
        checks++;
        if (Valid_o !== 1'b1 || RegWrite_o !== 1'b1 ||
            RdAddr_o !== 5'd3) begin
            errors++;
            $display("FAIL first_add got v=%b rw=%b rd=%0d exp 1 1 3",
                     Valid_o, RegWrite_o, RdAddr_o);
        end
        checks++;
        if (OperandA_o !== 32'd10 || OperandB_o !== 32'd20 ||
            ALUOp_o !== 2'b10) begin
            errors++;
            $display("FAIL first_ops got %h %h %b exp a 14 10",
                     OperandA_o, OperandB_o, ALUOp_o);
        end
        checks++;
        if (Funct3_o !== 3'b101 || Funct7_o !== 7'h20) begin
            errors++;
            $display("FAIL funct got %b %h exp 101 20",
                     Funct3_o, Funct7_o);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (Valid_o !== 1'b0 || RegWrite_o !== 1'b0 ||
            OperandA_o !== 0 || Funct7_o !== 0) begin
            errors++;
            $display("FAIL mid_reset got v=%b rw=%b a=%h f7=%h exp 0",
                     Valid_o, RegWrite_o, OperandA_o, Funct7_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (Valid_o !== 1'b1 || RdAddr_o !== 5'd3) begin
            errors++;
            $display("FAIL post_reset got v=%b rd=%0d exp 1 3",
                     Valid_o, RdAddr_o);
        end
    endtask

    task automatic test_forward();
        clr_fwd();
        drive(5'd5, 5'd6, 5'd3, 32'h11, 32'h22, 32'd0, 32'h44,
              2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        ExMemRegWrite_i = 1'b1;
        ExMemRd_i       = 5'd5;
        ExMemResult_i   = 32'h1234;
        MemWbRegWrite_i = 1'b1;
        MemWbRd_i       = 5'd5;
        MemWbResult_i   = 32'hBEEF;
        #1;
        checks++;
        if (OperandA_o !== 32'h1234) begin
            errors++;
            $display("FAIL fwd_exmem got %h exp 1234", OperandA_o);
        end
        ExMemRegWrite_i = 1'b0;
        #1;
        checks++;
        if (OperandA_o !== 32'hBEEF) begin
            errors++;
            $display("FAIL fwd_memwb got %h exp beef", OperandA_o);
        end
        MemWbRegWrite_i = 1'b0;
        #1;
        checks++;
        if (OperandA_o !== 32'h11) begin
            errors++;
            $display("FAIL fwd_rf got %h exp 11", OperandA_o);
        end
        MemWbRegWrite_i = 1'b1;
        MemWbRd_i       = 5'd6;
        MemWbResult_i   = 32'h5555;
        #1;
        checks++;
        if (OperandB_o !== 32'h5555 || StoreData_o !== 32'h5555) begin
            errors++;
            $display("FAIL fwd_rs2 got %h %h exp 5555",
                     OperandB_o, StoreData_o);
        end
        clr_fwd();
        drive(5'd1, 5'd0, 5'd4, 32'd1, 32'd0, 32'd0, 32'h48,
              2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        ExMemRegWrite_i = 1'b1;
        ExMemRd_i       = 5'd0;
        ExMemResult_i   = 32'hFFFF_FFFF;
        MemWbRegWrite_i = 1'b1;
        MemWbRd_i       = 5'd0;
        MemWbResult_i   = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (OperandB_o !== 0 || StoreData_o !== 0) begin
            errors++;
            $display("FAIL x0_guard got %h %h exp 0",
                     OperandB_o, StoreData_o);
        end
        clr_fwd();
    endtask

    task automatic test_load_use();
        drive(5'd2, 5'd0, 5'd7, 32'h100, 32'd0, 32'd4, 32'h50,
              2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if (MemRead_o !== 1'b1 || MemToReg_o !== 1'b1 ||
            OperandB_o !== 32'd4) begin
            errors++;
            $display("FAIL lw_stage got mr=%b m2r=%b b=%h exp 1 1 4",
                     MemRead_o, MemToReg_o, OperandB_o);
        end
        drive(5'd7, 5'd1, 5'd8, 32'd0, 32'd3, 32'd0, 32'h54,
              2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (LoadUseStall_o !== 1'b1) begin
            errors++;
            $display("FAIL lus_set got %b exp 1", LoadUseStall_o);
        end
        step();
        checks++;
        if (Valid_o !== 1'b0 || RegWrite_o !== 1'b0 ||
            MemRead_o !== 1'b0 || MemToReg_o !== 1'b0 ||
            ALUOp_o !== 2'b00) begin
            errors++;
            $display("FAIL bubble got v=%b rw=%b mr=%b op=%b exp 0",
                     Valid_o, RegWrite_o, MemRead_o, ALUOp_o);
        end
        checks++;
        if (LoadUseStall_o !== 1'b0) begin
            errors++;
            $display("FAIL lus_once got %b exp 0", LoadUseStall_o);
        end
        step();
        checks++;
        if (Valid_o !== 1'b1 || RdAddr_o !== 5'd8 ||
            ALUOp_o !== 2'b10) begin
            errors++;
            $display("FAIL add_after got v=%b rd=%0d op=%b exp 1 8 10",
                     Valid_o, RdAddr_o, ALUOp_o);
        end
        drive(5'd2, 5'd0, 5'd7, 32'h100, 32'd0, 32'd4, 32'h58,
              2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        drive(5'd1, 5'd7, 5'd9, 32'd0, 32'd0, 32'd8, 32'h5C,
              2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (LoadUseStall_o !== 1'b0) begin
            errors++;
            $display("FAIL lus_unused got %b exp 0", LoadUseStall_o);
        end
        step();
        checks++;
        if (Valid_o !== 1'b1 || RdAddr_o !== 5'd9) begin
            errors++;
            $display("FAIL no_bubble got v=%b rd=%0d exp 1 9",
                     Valid_o, RdAddr_o);
        end
    endtask

    task automatic test_stall_flush();
        drive(5'd1, 5'd2, 5'd9, 32'h99, 32'h1, 32'd0, 32'h60,
              2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(5'd1, 5'd2, 5'd10, 32'hAA, 32'h2, 32'd0, 32'h64,
              2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        Stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (Valid_o !== 1'b1 || RdAddr_o !== 5'd9 ||
                OperandA_o !== 32'h99) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b rd=%0d a=%h",
                         i, Valid_o, RdAddr_o, OperandA_o);
            end
        end
        Flush_i = 1'b1;
        step();
        checks++;
        if (Valid_o !== 1'b0 || RegWrite_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_wins got v=%b rw=%b exp 0 0",
                     Valid_o, RegWrite_o);
        end
        Flush_i = 1'b0;
        Stall_i = 1'b0;
        step();
        checks++;
        if (Valid_o !== 1'b1 || RdAddr_o !== 5'd10) begin
            errors++;
            $display("FAIL after_flush got v=%b rd=%0d exp 1 10",
                     Valid_o, RdAddr_o);
        end
        Stall_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (Valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_reset got %b exp 0", Valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (Valid_o !== 1'b0 || RegWrite_o !== 1'b0) begin
            errors++;
            $display("FAIL stale got v=%b rw=%b exp 0 0",
                     Valid_o, RegWrite_o);
        end
        Stall_i = 1'b0;
        drive(5'd2, 5'd0, 5'd7, 32'h100, 32'd0, 32'd4, 32'h68,
              2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        drive(5'd7, 5'd1, 5'd8, 32'd0, 32'd3, 32'd0, 32'h6C,
              2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        Stall_i = 1'b1;
        step();
        checks++;
        if (MemRead_o !== 1'b1 || LoadUseStall_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_hazard got mr=%b lus=%b exp 1 1",
                     MemRead_o, LoadUseStall_o);
        end
        Stall_i = 1'b0;
        step();
        checks++;
        if (Valid_o !== 1'b0 || MemRead_o !== 1'b0) begin
            errors++;
            $display("FAIL hazard_bubble got v=%b mr=%b exp 0 0",
                     Valid_o, MemRead_o);
        end
        step();
        checks++;
        if (Valid_o !== 1'b1 || RdAddr_o !== 5'd8) begin
            errors++;
            $display("FAIL hazard_resume got v=%b rd=%0d exp 1 8",
                     Valid_o, RdAddr_o);
        end
    endtask

    task automatic test_pc_imm();
        drive(5'd0, 5'd0, 5'd5, 32'h77, 32'd0, 32'h2000, 32'h100,
              2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (OperandA_o !== 32'h100 || OperandB_o !== 32'h2000 ||
            ALUOp_o !== 2'b00 || Pc_o !== 32'h100) begin
            errors++;
            $display("FAIL auipc got %h %h %b %h exp 100 2000 00 100",
                     OperandA_o, OperandB_o, ALUOp_o, Pc_o);
        end
        drive(5'd3, 5'd0, 5'd5, 32'h77, 32'd0, 32'h3000, 32'h104,
              2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (OperandA_o !== 0 || OperandB_o !== 32'h3000) begin
            errors++;
            $display("FAIL asel_zero got %h %h exp 0 3000",
                     OperandA_o, OperandB_o);
        end
        drive(5'd3, 5'd0, 5'd5, 32'h77, 32'd0, 32'h4000, 32'h108,
              2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (OperandA_o !== 0) begin
            errors++;
            $display("FAIL asel_11 got %h exp 0", OperandA_o);
        end
        Valid_i = 1'b0;
        step();
        checks++;
        if (Valid_o !== 1'b0 || RegWrite_o !== 1'b0 ||
            Pc_o !== 0) begin
            errors++;
            $display("FAIL invalid_in got v=%b rw=%b pc=%h exp 0",
                     Valid_o, RegWrite_o, Pc_o);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        Stall_i = 1'b0;
        Flush_i = 1'b0;
        clr_fwd();
        drive(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0,
              2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        Valid_i = 1'b0;
        step();
        step();
        test_reset();
        test_forward();
        test_load_use();
        test_stall_flush();
        test_pc_imm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the EX-stage ALU + ALU-control pair.
- Registers decoded instruction fields and control bits.
- Resolves EX/MEM and MEM/WB data forwarding.
- Produces final OperandA/OperandB, Funct3, Funct7 and ALUOp for the ALU, plus downstream control for MEM/WB.
- Detects load-use hazards, inserts bubbles, and honours stall/flush from the hazard/branch logic.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
Clk_i  in  1  clock, rising edge
Rst_ni  in  1  asynchronous active-low reset
Valid_i  in  1  decode slot holds a real instruction
Pc_i  in  XLEN  instruction PC
Rs1Data_i  in  XLEN  register-file rs1 read data
Rs2Data_i  in  XLEN  register-file rs2 read data
Imm_i  in  XLEN  sign-extended immediate
Rs1Addr_i  in  REG_AW  rs1 index
Rs2Addr_i  in  REG_AW  rs2 index
RdAddr_i  in  REG_AW  rd index
UseRs1_i  in  1  instruction reads rs1
UseRs2_i  in  1  instruction reads rs2
Funct3_i  in  3  funct3
Funct7_i  in  7  funct7
ALUOp_i  in  2  ALU op class
ASel_i  in  2  OperandA select: 00 rs1, 01 PC, 10 zero
ALUSrc_i  in  1  OperandB select: 0 rs2, 1 Imm
RegWrite_i  in  1  writes rd
MemRead_i  in  1  load
MemWrite_i  in  1  store
MemToReg_i  in  1  WB selects memory data
Stall_i  in  1  hold stage contents (downstream stall)
Flush_i  in  1  kill stage contents (branch redirect)
ExMemRegWrite_i  in  1  EX/MEM writes rd
ExMemRd_i  in  REG_AW  EX/MEM rd
ExMemResult_i  in  XLEN  EX/MEM ALU result
MemWbRegWrite_i  in  1  MEM/WB writes rd
MemWbRd_i  in  REG_AW  MEM/WB rd
MemWbResult_i  in  XLEN  MEM/WB write-back data
OperandA_o  out  XLEN  to ALU OperandA_i
OperandB_o  out  XLEN  to ALU OperandB_i
Funct3_o  out  3  to ALU/ALU control
Funct7_o  out  7  to ALU control
ALUOp_o  out  2  to ALU control
StoreData_o  out  XLEN  forwarded rs2, for stores
Pc_o  out  XLEN  registered PC
RdAddr_o  out  REG_AW  registered rd
Valid_o  out  1  stage holds a real instruction
RegWrite_o  out  1  gated control: 0 when Valid_o=0
MemRead_o  out  1  gated control: 0 when Valid_o=0
MemWrite_o  out  1  gated control: 0 when Valid_o=0
MemToReg_o  out  1  gated control: 0 when Valid_o=0
LoadUseStall_o  out  1  combinational; upstream must hold PC and IF/ID

Behaviour:
- Reset: asynchronous, Rst_ni low; all registers clear to 0. All outputs read 0, including Valid_o, ALUOp_o=00 and LoadUseStall_o.
- Latency: one cycle from decode inputs to outputs. Forwarding muxes are combinational on registered rs addresses.
- Update priority on each rising edge:
  - Flush_i: load bubble.
  - else Stall_i: hold all registers.
  - else LoadUseStall_o: load bubble.
  - else capture inputs.
- Bubble: Valid=0; RegWrite/MemRead/MemWrite/MemToReg=0; ALUOp=00; all other fields 0.
- Valid_i=0 captured as a bubble.
- LoadUseStall_o = Valid_o & MemRead_o & Valid_i & (RdAddr_o!=0) & ((UseRs1_i & Rs1Addr_i==RdAddr_o) | (UseRs2_i & Rs2Addr_i==RdAddr_o)). Exactly one bubble per hazard.
- Forwarding, per operand (rs1q/rs2q = registered addresses):
  - EX/MEM when ExMemRegWrite_i & ExMemRd_i!=0 & ExMemRd_i==rsq.
  - else MEM/WB when MemWbRegWrite_i & MemWbRd_i!=0 & MemWbRd_i==rsq.
  - else registered register-file data.
  - x0 is never forwarded; EX/MEM has priority.
- OperandA_o: ASel=00 forwarded rs1, 01 Pc, 10 zero, 11 zero.
- OperandB_o: ALUSrc ? Imm : forwarded rs2.
- StoreData_o: always forwarded rs2.
- Stall_i with hazard active: hold; hazard re-evaluated the next cycle.
- Flush_i with Stall_i: flush wins.
- Reset mid-stall: stage empties; no stale instruction survives.

Decomposition:
- Shared package riscv_pkg:
  - ALUOp encodings: 00 add (ld/st), 01 branch, 10 R-type, 11 I-type.
  - ASel encodings.
  - XLEN/REG_AW constants.
  - Forward-select enum {FWD_RF, FWD_EXMEM, FWD_MEMWB}.
- One sub-module, forward_unit: combinational forward select + mux, instantiated once per operand.

Test Plan:
- Reset: Rst_ni=0 mid-stream -> all outputs 0 immediately; after release, first captured ADD appears one cycle later with Valid_o=1.
- R-type forward: ADD x3 in stage with rs1q=5; ExMemRd_i=5, ExMemRegWrite_i=1, ExMemResult_i=0x1234; MemWbRd_i=5, MemWbResult_i=0xBEEF -> OperandA_o=0x1234 (EX/MEM priority).
- x0 guard: rs2q=0, ExMemRd_i=0, ExMemResult_i=0xFFFF_FFFF, Rs2Data=0 -> OperandB_o=0.
- Load-use: LW x7 in stage, decode ADD x8,x7,x1 -> LoadUseStall_o=1 for exactly one cycle; next Valid_o=0 with all controls 0; following cycle ADD captured.
- Stall/flush: Stall_i=1 for 3 cycles -> outputs unchanged; Stall_i=1 with Flush_i=1 -> bubble next cycle.
- Immediate/PC: AUIPC with Pc_i=0x100, Imm_i=0x2000, ASel=01, ALUSrc=1 -> OperandA_o=0x100, OperandB_o=0x2000, ALUOp_o=00.
